// File: rtl/oled_write_arbiter_pkg.sv
// Shared OLED types: buffer path widths, arbiter refresh states and index helpers.
package OledTypes;

   localparam int OLED_INDEX_WIDTH = 9;
   localparam int OLED_CHAR_WIDTH  = 8;

   typedef logic [OLED_INDEX_WIDTH-1:0] OledIndexPath;
   typedef logic [OLED_CHAR_WIDTH-1:0]  OledCharPath;

   typedef enum logic [1:0] {IDLE, DIRTY, REQ} OledArbState;

   localparam OledCharPath OLED_BLANK_CHAR = 8'h20;

   // The buffer is addressed per 8-pixel cell, so the low three index bits are dropped.
   function automatic OledIndexPath cellIndex(input OledIndexPath idx);
      return {idx[OLED_INDEX_WIDTH-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/oled_write_arbiter_picker.sv
// Combinational round-robin picker: first request at or after ptr, modulo NUM_REQ.
module rr_priority_picker #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grantId,
   output logic               anyGrant
);

   int j;

   // Scan farthest-first so the candidate closest to ptr is the last one written.
   always_comb begin
      grant    = '0;
      grantId  = '0;
      anyGrant = 1'b0;
      j        = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            grantId  = ID_W'(j);
            anyGrant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_write_arbiter.sv
// Round-robin share of the OLED character-buffer write port plus refresh scheduling.
// Optional write statistics counter enabled by defining OLED_ARB_STATS_EN.
module oled_write_arbiter
   import OledTypes::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int REFRESH_HOLDOFF = 1024,
   localparam int ID_W           = $clog2(NUM_REQ),
   localparam int HOLD_W         = $clog2(REFRESH_HOLDOFF + 1)
) (
   input  logic                                  clk,
   input  logic                                  rstN,
   input  logic [NUM_REQ-1:0]                    reqValid,
   output logic [NUM_REQ-1:0]                    reqReady,
   input  logic [NUM_REQ*OLED_INDEX_WIDTH-1:0]   reqIndex,
   input  logic [NUM_REQ*OLED_CHAR_WIDTH-1:0]    reqData,
   output logic                                  bufWrite,
   output OledIndexPath                          bufIndex,
   output OledCharPath                           bufData,
   output logic [ID_W-1:0]                       grantId,
   output logic                                  refreshReq,
   input  logic                                  refreshAck,
   output logic                                  dirty,
   output logic [15:0]                           writeCount
);

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   pickId;
   logic              xfer;
   OledIndexPath      selIndex;
   OledCharPath       selData;
   OledArbState       state, stateNext;
   logic [HOLD_W-1:0] hold, holdNext;

   rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) picker (
      .req      (reqValid),
      .ptr      (ptr),
      .grant    (reqReady),
      .grantId  (pickId),
      .anyGrant (xfer)
   );

   assign selIndex = reqIndex[int'(pickId)*OLED_INDEX_WIDTH +: OLED_INDEX_WIDTH];
   assign selData  = reqData[int'(pickId)*OLED_CHAR_WIDTH +: OLED_CHAR_WIDTH];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= (int'(pickId) == NUM_REQ - 1) ? '0 : pickId + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         bufWrite <= 1'b0;
         bufIndex <= '0;
         bufData  <= OLED_BLANK_CHAR;
         grantId  <= '0;
      end else begin
         bufWrite <= xfer;
         if (xfer) begin
            bufIndex <= cellIndex(selIndex);
            bufData  <= selData;
            grantId  <= pickId;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         state <= stateNext;
         hold  <= holdNext;
      end
   end

   // hold parks at the threshold once REQ is reached, so it never wraps.
   always_comb begin
      stateNext = state;
      holdNext  = hold;
      case (state)
         IDLE: begin
            if (xfer) begin
               stateNext = DIRTY;
               holdNext  = '0;
            end
         end
         DIRTY: begin
            if (hold == HOLD_W'(REFRESH_HOLDOFF - 1)) stateNext = REQ;
            else                                      holdNext  = hold + 1'b1;
         end
         REQ: begin
            // A write landing with the ack missed that refresh and restarts the hold-off.
            if (refreshAck) begin
               if (xfer) begin
                  stateNext = DIRTY;
                  holdNext  = '0;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
            holdNext  = '0;
         end
      endcase
   end

   assign refreshReq = (state == REQ);
   assign dirty      = (state != IDLE);

`ifdef OLED_ARB_STATS_EN
   logic [15:0] count;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         count <= '0;
      end else if (xfer && count != 16'hFFFF) begin
         count <= count + 16'd1;
      end
   end

   assign writeCount = count;
`else
   assign writeCount = 16'd0;
`endif

endmodule

// File: tb/tb_oled_write_arbiter.sv
// Self-checking bench: constant vector table, directed refresh sequences, random vs timestamp model.
module tb_oled_write_arbiter;

   localparam int N  = 3;
   localparam int H  = 4;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            rstN = 1'b0;
   logic [N-1:0]    reqValid = '0;
   logic [N-1:0]    reqReady;
   logic [N*9-1:0]  reqIndex = '0;
   logic [N*8-1:0]  reqData = '0;
   logic            bufWrite;
   logic [8:0]      bufIndex;
   logic [7:0]      bufData;
   logic [IW-1:0]   grantId;
   logic            refreshReq;
   logic            refreshAck = 1'b0;
   logic            dirty;
   logic [15:0]     writeCount;

   oled_write_arbiter #(.NUM_REQ(N), .REFRESH_HOLDOFF(H)) dut (
      .clk        (clk),
      .rstN       (rstN),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqIndex   (reqIndex),
      .reqData    (reqData),
      .bufWrite   (bufWrite),
      .bufIndex   (bufIndex),
      .bufData    (bufData),
      .grantId    (grantId),
      .refreshReq (refreshReq),
      .refreshAck (refreshAck),
      .dirty      (dirty),
      .writeCount (writeCount)
   );

   always #5 clk = ~clk;

   int nChk = 0;
   int nFail = 0;

   // Reference model: pointer, last write, and the cycle stamp of the oldest unflushed write.
   int          cyc = 0;
   int          mPtr, mGid, mSince, mCount;
   bit          mDirty, mWr;
   logic [8:0]  mIdx;
   logic [7:0]  mData;
   logic [N-1:0] lastStall = '0;

   typedef struct {
      logic [N-1:0] v;
      logic [8:0]   idx;
      logic [7:0]   d;
      logic [N-1:0] expReady;
      logic         expWr;
      logic [8:0]   expIdx;
      logic [7:0]   expData;
      int           expGid;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic modelReset();
      mPtr = 0; mGid = 0; mSince = 0; mCount = 0;
      mDirty = 0; mWr = 0; mIdx = '0; mData = 8'h20;
      lastStall = '0;
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic bit mReq();
      return mDirty && (cyc - mSince >= H + 1);
   endfunction

   task automatic checkOutputs();
      chk("bufWrite",   32'(bufWrite),   32'(mWr));
      chk("bufIndex",   32'(bufIndex),   32'(mIdx));
      chk("bufData",    32'(bufData),    32'(mData));
      chk("grantId",    32'(grantId),    32'(mGid));
      chk("refreshReq", 32'(refreshReq), 32'(mReq()));
      chk("dirty",      32'(dirty),      32'(mDirty));
      chk("writeCount", 32'(writeCount), 32'(mCount));
   endtask

   // Called with clk low; applies one cycle of inputs and checks the following cycle.
   task automatic step(input logic [N-1:0] v, input logic ack,
                       input logic [N*9-1:0] idx, input logic [N*8-1:0] dat);
      int  g;
      bit  req;
      reqValid = v; refreshAck = ack; reqIndex = idx; reqData = dat;
      #1;
      g = pick(v, mPtr);
      chk("reqReady", 32'(reqReady), (g < 0) ? 32'd0 : (32'd1 << g));
      lastStall = v & ~((g < 0) ? '0 : N'(1 << g));
      req = mReq();
      if (g >= 0) begin
         mWr = 1; mGid = g; mPtr = (g + 1) % N;
         mIdx = {idx[g*9+3 +: 6], 3'b000};
         mData = dat[g*8 +: 8];
`ifdef OLED_ARB_STATS_EN
         if (mCount < 16'hFFFF) mCount++;
`endif
      end else begin
         mWr = 0;
      end
      if (req && ack) begin
         if (g >= 0) mSince = cyc;
         else        mDirty = 0;
      end else if (!mDirty && g >= 0) begin
         mDirty = 1; mSince = cyc;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      checkOutputs();
   endtask

   task automatic doReset();
      rstN = 1'b0; reqValid = '0; refreshAck = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      modelReset();
      @(negedge clk);
      checkOutputs();
      chk("rst_bufData", 32'(bufData), 32'h20);
      chk("rst_dirty",   32'(dirty),   32'd0);
   endtask

   task automatic idle(input int n, input logic ack);
      for (int k = 0; k < n; k++) step('0, ack, reqIndex, reqData);
   endtask

   logic [N*9-1:0] rIdx;
   logic [N*8-1:0] rDat;

   initial begin
      tbl[0] = '{3'b011, 9'h0AF, 8'h41, 3'b001, 1'b1, 9'h0A8, 8'h41, 0};
      tbl[1] = '{3'b011, 9'h1FF, 8'h50, 3'b010, 1'b1, 9'h1F8, 8'h51, 1};
      tbl[2] = '{3'b011, 9'h107, 8'h60, 3'b001, 1'b1, 9'h100, 8'h60, 0};
      tbl[3] = '{3'b100, 9'h0F0, 8'h70, 3'b100, 1'b1, 9'h0F0, 8'h72, 2};
      tbl[4] = '{3'b000, 9'h055, 8'h11, 3'b000, 1'b0, 9'h0F0, 8'h72, 2};
      tbl[5] = '{3'b010, 9'h0AF, 8'h40, 3'b010, 1'b1, 9'h0A8, 8'h41, 1};
      tbl[6] = '{3'b110, 9'h023, 8'h30, 3'b100, 1'b1, 9'h020, 8'h32, 2};
      tbl[7] = '{3'b111, 9'h1C9, 8'h20, 3'b001, 1'b1, 9'h1C8, 8'h20, 0};

      modelReset();
      doReset();

      // Vector table from a fresh pointer.
      for (int e = 0; e < 8; e++) begin
         for (int i = 0; i < N; i++) begin
            rIdx[i*9 +: 9] = tbl[e].idx;
            rDat[i*8 +: 8] = tbl[e].d + 8'(i);
         end
         reqValid = tbl[e].v; reqIndex = rIdx; reqData = rDat; #1;
         chk("tbl_ready", 32'(reqReady), 32'(tbl[e].expReady));
         step(tbl[e].v, 1'b0, rIdx, rDat);
         chk("tbl_wr",   32'(bufWrite), 32'(tbl[e].expWr));
         chk("tbl_idx",  32'(bufIndex), 32'(tbl[e].expIdx));
         chk("tbl_data", 32'(bufData),  32'(tbl[e].expData));
         chk("tbl_gid",  32'(grantId),  32'(tbl[e].expGid));
      end

      // Two busy requesters alternate.
      doReset();
      for (int k = 0; k < 6; k++) begin
         step(3'b011, 1'b0, {N{9'h012}}, {N{8'h33}});
         chk("rr_wr",  32'(bufWrite), 32'd1);
         chk("rr_gid", 32'(grantId),  32'(k % 2));
      end

      // Hold-off timing and plain ack.
      doReset();
      step(3'b001, 1'b0, {N{9'h040}}, {N{8'h44}});
      chk("ho_dirty", 32'(dirty), 32'd1);
      for (int k = 1; k <= H; k++) begin
         idle(1, 1'b0);
         chk("ho_req", 32'(refreshReq), 32'(k == H));
      end
      idle(4, 1'b0);
      chk("ho_req_held", 32'(refreshReq), 32'd1);
      idle(1, 1'b1);
      chk("ack_req",   32'(refreshReq), 32'd0);
      chk("ack_dirty", 32'(dirty),      32'd0);

      // Ack coinciding with a write restarts the hold-off from that write.
      step(3'b010, 1'b0, {N{9'h080}}, {N{8'h45}});
      idle(H, 1'b0);
      chk("aw_req_up", 32'(refreshReq), 32'd1);
      step(3'b001, 1'b1, {N{9'h0C0}}, {N{8'h46}});
      chk("aw_req",   32'(refreshReq), 32'd0);
      chk("aw_dirty", 32'(dirty),      32'd1);
      for (int k = 1; k <= H; k++) begin
         idle(1, 1'b0);
         chk("aw_rerise", 32'(refreshReq), 32'(k == H));
      end

      // Asynchronous reset while a refresh is requested.
      @(posedge clk); #2;
      rstN = 1'b0; #1;
      chk("arst_req",   32'(refreshReq), 32'd0);
      chk("arst_dirty", 32'(dirty),      32'd0);
      chk("arst_wr",    32'(bufWrite),   32'd0);
      @(negedge clk);
      cyc++;
      rstN = 1'b1;
      modelReset();
      @(negedge clk);
      cyc++;
      checkOutputs();

      // Random traffic; stalled requesters keep their payload stable.
      rIdx = '0; rDat = '0;
      for (int t = 0; t < 600; t++) begin
         logic [N-1:0] v;
         v = N'($urandom_range(0, (1 << N) - 1)) | lastStall;
         for (int i = 0; i < N; i++) begin
            if (!lastStall[i]) begin
               rIdx[i*9 +: 9] = 9'($urandom);
               rDat[i*8 +: 8] = 8'($urandom);
            end
         end
         step(v, ($urandom_range(0, 5) == 0), rIdx, rDat);
      end

`ifdef OLED_ARB_STATS_EN
      for (int t = 0; t < 70000; t++) step('1, 1'b0, rIdx, rDat);
      chk("stats_sat", 32'(writeCount), 32'hFFFF);
`else
      chk("stats_off", 32'(writeCount), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
      $finish;
   end

endmodule
